linked_list_mqueue: RTL and testbench

LINKED_LIST_MQUEUE -- requirements
Module: linked_list_mqueue

---
 rtl/linked_list_mqueue.sv | 176 +++++++++++++++++
 tb/tb_linked_list_mqueue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/linked_list_mqueue.sv
// linked_list_mqueue
//   QUEUES independent FIFOs that share one pool of DEPTH linked-list nodes.
//   Each queue keeps a sentinel node at its tail, so DEPTH-QUEUES entries are
//   usable. After reset the block spends DEPTH cycles (INIT) threading the
//   free list, then raises ready.
//
// Ports
//   clk, rst          clock (rising edge), async active-low reset
//   push, push_q, d   enqueue d onto queue push_q
//   pop, pop_q        dequeue from queue pop_q
//   q, q_valid        popped data, valid the cycle after an accepted pop
//   ready             INIT done, requests honoured
//   empty, count      per-queue flags / occupancy (queue i at [i*CW +: CW])
//   free_count, full, almost_full   free-pool status
//   err_clr, overflow, underflow    sticky reject flags and their clear
module linked_list_mqueue #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int QUEUES    = 8,
  parameter int AF_MARGIN = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int QW = $clog2(QUEUES),
  localparam int CW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [QW-1:0]        push_q,
  input  logic [WIDTH-1:0]     d,
  input  logic                 pop,
  input  logic [QW-1:0]        pop_q,
  output logic [WIDTH-1:0]     q,
  output logic                 q_valid,
  output logic                 ready,
  output logic [QUEUES-1:0]    empty,
  output logic [QUEUES*CW-1:0] count,
  output logic [CW-1:0]        free_count,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_init_cnt;

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [AW-1:0]    r_next [DEPTH];

  logic [AW-1:0]    r_head [QUEUES];
  logic [AW-1:0]    r_tail [QUEUES];
  logic [AW-1:0]    r_free_head;
  logic [CW-1:0]    r_count [QUEUES];
  logic [CW-1:0]    r_free_count;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid, r_ovf, r_unf;

  logic             w_ready, w_pop_acc, w_push_acc;
  logic [QUEUES-1:0] w_empty;
  logic [AW-1:0]    w_pop_node, w_pop_next, w_push_tail, w_new_node, w_free_next;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_init_cnt == AW'(DEPTH - 1)) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_init_cnt <= '0;
    else if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
  end

  // ---------------- request decode ----------------
  assign w_ready = (r_state == S_RUN);

  for (genvar gi = 0; gi < QUEUES; gi++) begin : g_q
    assign w_empty[gi]            = (r_count[gi] == '0);
    assign count[gi*CW +: CW]     = r_count[gi];
  end

  // Pop is judged on the pre-edge occupancy, so a push to an empty queue in
  // the same cycle cannot satisfy it.
  assign w_pop_acc  = w_ready & pop & ~w_empty[pop_q];
  // A same-cycle pop frees a node, so a push is allowed even with no free node.
  assign w_push_acc = w_ready & push & ((r_free_count != '0) | w_pop_acc);

  assign w_pop_node  = r_head[pop_q];
  assign w_pop_next  = r_next[w_pop_node];
  assign w_push_tail = r_tail[push_q];
  assign w_free_next = r_next[r_free_head];
  // The popped node becomes the new sentinel directly; free list untouched.
  assign w_new_node  = w_pop_acc ? w_pop_node : r_free_head;

  // ---------------- RAMs (not reset) ----------------
  // One next-pointer write per cycle: INIT threading, push link, or
  // returning a popped node to the front of the free list.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT)  r_next[r_init_cnt]  <= r_init_cnt + 1'b1;
    else if (w_push_acc)    r_next[w_push_tail] <= w_new_node;
    else if (w_pop_acc)     r_next[w_pop_node]  <= r_free_head;
    if (w_push_acc)         r_data[w_push_tail] <= d;
  end

  // ---------------- pointers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUES; i++) begin
        r_head[i] <= AW'(i);
        r_tail[i] <= AW'(i);
      end
      r_free_head <= AW'(QUEUES);
    end else if (r_state == S_INIT) begin
      for (int i = 0; i < QUEUES; i++) begin
        r_head[i] <= AW'(i);
        r_tail[i] <= AW'(i);
      end
      r_free_head <= AW'(QUEUES);
    end else begin
      if (w_pop_acc)  r_head[pop_q]  <= w_pop_next;
      if (w_push_acc) r_tail[push_q] <= w_new_node;
      if (w_push_acc && !w_pop_acc)      r_free_head <= w_free_next;
      else if (w_pop_acc && !w_push_acc) r_free_head <= w_pop_node;
    end
  end

  // ---------------- occupancy ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUES; i++) r_count[i] <= '0;
      r_free_count <= CW'(DEPTH - QUEUES);
    end else begin
      for (int i = 0; i < QUEUES; i++) begin
        if (w_push_acc && push_q == QW'(i) && !(w_pop_acc && pop_q == QW'(i)))
          r_count[i] <= r_count[i] + 1'b1;
        else if (w_pop_acc && pop_q == QW'(i) && !(w_push_acc && push_q == QW'(i)))
          r_count[i] <= r_count[i] - 1'b1;
      end
      if (w_push_acc && !w_pop_acc)      r_free_count <= r_free_count - 1'b1;
      else if (w_pop_acc && !w_push_acc) r_free_count <= r_free_count + 1'b1;
    end
  end

  // ---------------- read data and sticky errors ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_pop_acc) r_q <= r_data[w_pop_node];
      r_q_valid <= w_pop_acc;
      r_ovf <= (r_ovf & ~err_clr) | (w_ready & push & ~w_push_acc);
      r_unf <= (r_unf & ~err_clr) | (w_ready & pop & ~w_pop_acc);
    end
  end

  assign q           = r_q;
  assign q_valid     = r_q_valid;
  assign ready       = w_ready;
  assign empty       = w_empty;
  assign free_count  = r_free_count;
  assign full        = (r_free_count == '0);
  assign almost_full = (r_free_count <= CW'(AF_MARGIN));
  assign overflow    = r_ovf;
  assign underflow   = r_unf;

endmodule

// File: tb/tb_linked_list_mqueue.sv
// Bench for linked_list_mqueue: per-queue data queues model + directed scenarios.
module tb_linked_list_mqueue;
  localparam int Q = 8, D = 64, CW = 7, CAP = 56, AFM = 2;

  logic clk = 0, rst = 0, push = 0, pop = 0, err_clr = 0;
  logic [2:0] push_q = 0, pop_q = 0;
  logic [7:0] d = 0;
  logic [7:0] q, empty;
  logic q_valid, ready, full, almost_full, overflow, underflow;
  logic [Q*CW-1:0] count;
  logic [CW-1:0] free_count;

  linked_list_mqueue #(.WIDTH(8), .DEPTH(D), .QUEUES(Q), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .push(push), .push_q(push_q), .d(d),
    .pop(pop), .pop_q(pop_q), .q(q), .q_valid(q_valid), .ready(ready),
    .empty(empty), .count(count), .free_count(free_count), .full(full),
    .almost_full(almost_full), .err_clr(err_clr), .overflow(overflow),
    .underflow(underflow));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt(int i);
    return 32'(count[i*CW +: CW]);
  endfunction

  // ---------------- model ----------------
  logic [7:0] mq[Q][$];
  int  m_cyc = 0;
  bit  m_ready = 0, m_ovf = 0, m_unf = 0, m_qv = 0;
  logic [7:0] m_q = 0;

  always @(posedge clk or negedge rst) begin : mdl
    int tot;
    bit pok, sok;
    if (!rst) begin
      for (int i = 0; i < Q; i++) mq[i].delete();
      m_cyc = 0; m_ready = 0; m_ovf = 0; m_unf = 0; m_qv = 0; m_q = 0;
    end else begin
      pok = 0; sok = 0;
      if (m_ready) begin
        tot = 0;
        for (int i = 0; i < Q; i++) tot += mq[i].size();
        pok = pop && mq[pop_q].size() > 0;
        sok = push && (tot < CAP || pok);
        if (pok) m_q = mq[pop_q].pop_front();
        if (sok) mq[push_q].push_back(d);
      end
      m_ovf = (m_ovf && !err_clr) || (m_ready && push && !sok);
      m_unf = (m_unf && !err_clr) || (m_ready && pop && !pok);
      m_qv  = pok;
      if (!m_ready) begin
        m_cyc++;
        if (m_cyc == D) m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int tot;
    logic [7:0] me;
    if (chk_en) begin
      tot = 0;
      for (int i = 0; i < Q; i++) begin
        tot += mq[i].size();
        me[i] = (mq[i].size() == 0);
        chk($sformatf("count%0d", i), cnt(i), 32'(mq[i].size()));
      end
      chk("ready", 32'(ready), 32'(m_ready));
      chk("q_valid", 32'(q_valid), 32'(m_qv));
      chk("q", 32'(q), 32'(m_q));
      chk("empty", 32'(empty), 32'(me));
      chk("free_count", 32'(free_count), 32'(CAP - tot));
      chk("full", 32'(full), 32'(tot == CAP));
      chk("almost_full", 32'(almost_full), 32'((CAP - tot) <= AFM));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("conserve", 32'(cnt(0)+cnt(1)+cnt(2)+cnt(3)+cnt(4)+cnt(5)+cnt(6)+cnt(7)+free_count), 32'(CAP));
    end
  end

  task automatic cyc(bit p, logic [2:0] pq, logic [7:0] dd, bit po, logic [2:0] poq, bit ec = 0);
    push = p; push_q = pq; d = dd; pop = po; pop_q = poq; err_clr = ec;
    @(negedge clk);
  endtask

  task automatic reset_vals(string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_qv"}, 32'(q_valid), 0);
    chk({tag, "_q"}, 32'(q), 0);
    chk({tag, "_free"}, 32'(free_count), 56);
    chk({tag, "_empty"}, 32'(empty), 32'hFF);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_unf"}, 32'(underflow), 0);
    chk({tag, "_cnt3"}, cnt(3), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset_vals("rst0");
    chk_en = 1;

    // Init: push held high, nothing accepted until ready
    rst = 1;
    n = 0;
    for (int k = 0; k < 200 && !ready; k++) begin
      cyc(1, 0, 8'h55, 0, 0);
      n++;
    end
    chk("init_len", 32'(n), 64);
    cyc(0, 0, 0, 0, 0);
    chk("init_cnt0", cnt(0), 0);
    chk("init_ovf", 32'(overflow), 0);

    // Two pushes then two pops on queue 3
    cyc(1, 3, 8'hA1, 0, 0);
    cyc(1, 3, 8'hA2, 0, 0);
    chk("q3_cnt2", cnt(3), 2);
    cyc(0, 0, 0, 1, 3);
    chk("pop1_qv", 32'(q_valid), 1);
    chk("pop1_q", 32'(q), 32'hA1);
    cyc(0, 0, 0, 1, 3);
    chk("pop2_q", 32'(q), 32'hA2);
    chk("q3_cnt0", cnt(3), 0);
    chk("q3_empty", 32'(empty[3]), 1);
    cyc(0, 0, 0, 0, 0);
    chk("hold_qv", 32'(q_valid), 0);
    chk("hold_q", 32'(q), 32'hA2);

    // Fill the pool
    for (int i = 0; i < 56; i++) begin
      cyc(1, 3'(i % 8), 8'(i), 0, 0);
      if (i == 52) chk("af_at3", 32'(almost_full), 0);
      if (i == 53) chk("af_at2", 32'(almost_full), 1);
    end
    chk("full", 32'(full), 1);
    chk("free0", 32'(free_count), 0);
    cyc(1, 0, 8'hEE, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    cyc(1, 0, 8'hBB, 1, 1, 1);
    chk("pp_full_q", 32'(q), 1);
    chk("pp_full_free", 32'(free_count), 0);
    chk("ovf_clr", 32'(overflow), 0);

    // Drain queue 5, then push+pop it while empty
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 5);
    chk("q5_last", 32'(q), 53);
    chk("q5_empty", 32'(empty[5]), 1);
    cyc(1, 5, 8'h77, 1, 5);
    chk("unf_set", 32'(underflow), 1);
    chk("q5_cnt1", cnt(5), 1);
    chk("unf_qv", 32'(q_valid), 0);
    cyc(0, 0, 0, 1, 5, 1);
    chk("q5_77", 32'(q), 32'h77);
    chk("unf_clr", 32'(underflow), 0);

    // Random traffic
    for (int k = 0; k < 10000; k++)
      cyc($urandom_range(0, 99) < 55, 3'($urandom), 8'($urandom),
          $urandom_range(0, 99) < 50, 3'($urandom), $urandom_range(0, 99) < 3);

    // Asynchronous reset mid-traffic
    push = 1; pop = 1; push_q = 2; pop_q = 2;
    #2 rst = 0;
    #1 reset_vals("arst");
    push = 0; pop = 0;
    @(negedge clk); @(negedge clk);
    rst = 1;
    repeat (64) cyc(0, 0, 0, 0, 0);
    chk("reinit_ready", 32'(ready), 1);
    chk("reinit_empty", 32'(empty), 32'hFF);
    chk("reinit_free", 32'(free_count), 56);
    cyc(1, 2, 8'h3C, 0, 0);
    cyc(0, 0, 0, 1, 2);
    chk("reinit_q", 32'(q), 32'h3C);
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
